// File: rtl/tusca_pkg.sv
// Shared definitions for the tusca datapath: FSM encodings, default timing
// constants and the DHT11 frame checksum helper.
package tusca_pkg;

  // FSM encodings; the numeric value is what db_estado shows.
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_START_LOW   = 3'd1;
  localparam logic [2:0] ST_ESPERA_RESP = 3'd2;
  localparam logic [2:0] ST_RESP_LOW    = 3'd3;
  localparam logic [2:0] ST_RESP_HIGH   = 3'd4;
  localparam logic [2:0] ST_BIT_LOW     = 3'd5;
  localparam logic [2:0] ST_BIT_HIGH    = 3'd6;
  localparam logic [2:0] ST_FIM         = 3'd7;

  // Default timing at a 50 MHz clock.
  localparam int unsigned START_LOW_CICLOS_DEF = 900_000; // 18 ms host start pulse
  localparam int unsigned LIMIAR_BIT_DEF       = 2_000;   // 40 us high width threshold
  localparam int unsigned TIMEOUT_FASE_DEF     = 5_000;   // 100 us per-phase limit

  // A DHT11 frame is always 40 bits: 4 data bytes plus a checksum byte.
  localparam int unsigned N_BITS = 40;

  // Frame layout (first received bit is bit 39):
  // [39:32] hum int, [31:24] hum dec, [23:16] temp int, [15:8] temp dec, [7:0] checksum.
  // The sum is truncated to 8 bits, so carries out of the byte are dropped.
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] w_sum;
    w_sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (w_sum == frame[7:0]);
  endfunction

endpackage

// File: rtl/dht11_reader_sync_2ff.sv
// Two-flop synchronizer for the asynchronous DHT11 bus level.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Flops reset to 1 because a released open-drain bus idles high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: host start pulse, sensor response, 40 data bits,
// checksum and per-phase timeout, results presented with a one-cycle pronto.
//
// Request/done protocol: medir is a request strobe accepted only while the FSM
// is in IDLE (no queuing, no back-pressure signal). Exactly one pronto pulse
// answers each accepted request; erro/erro_checksum/temperatura/umidade are
// valid from the pronto cycle until the next accepted request.
module dht11_reader
  import tusca_pkg::*;
#(
  parameter int unsigned START_LOW_CICLOS = START_LOW_CICLOS_DEF,
  parameter int unsigned LIMIAR_BIT       = LIMIAR_BIT_DEF,
  parameter int unsigned TIMEOUT_FASE     = TIMEOUT_FASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  inout  wire         dht_bus,
  output logic        pronto,
  output logic        erro,
  output logic        erro_checksum,
  output logic [15:0] temperatura,
  output logic [15:0] umidade,
  output logic [2:0]  db_estado
);

  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic [5:0]  r_idx;
  logic [39:0] r_shift;
  logic        r_timeout;
  logic        r_bus_prev;
  logic        r_pronto;
  logic        r_erro;
  logic        r_erro_cs;
  logic [15:0] r_temp;
  logic [15:0] r_umid;

  logic [2:0]  w_next;
  logic        w_bus_s;
  logic        w_rise;
  logic        w_fall;
  logic        w_wait_state;
  logic        w_phase_to;
  logic        w_to_fim_timeout;
  logic        w_bit;
  logic        w_last_bit;

  sync_2ff u_sync (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (dht_bus),
    .o_q   (w_bus_s)
  );

  // Open drain: only pull low during the host start pulse. Derived straight
  // from the state so an asynchronous reset releases the bus at once.
  assign dht_bus = (r_state == ST_START_LOW) ? 1'b0 : 1'bz;

  assign w_rise       = ~r_bus_prev &  w_bus_s;
  assign w_fall       =  r_bus_prev & ~w_bus_s;
  assign w_wait_state = (r_state >= ST_ESPERA_RESP) && (r_state <= ST_BIT_HIGH);
  assign w_phase_to   = w_wait_state && (r_cnt == TIMEOUT_FASE);
  assign w_last_bit   = (r_idx == 6'(N_BITS - 1));
  // On the falling edge r_cnt holds (high width - 1), hence the -1.
  assign w_bit        = (r_cnt >= LIMIAR_BIT - 1);

  // Next-state logic; a detected edge takes priority over the phase timeout.
  always_comb begin
    w_next           = r_state;
    w_to_fim_timeout = 1'b0;
    case (r_state)
      ST_IDLE:        if (medir) w_next = ST_START_LOW;
      ST_START_LOW:   if (r_cnt == START_LOW_CICLOS - 1) w_next = ST_ESPERA_RESP;
      ST_ESPERA_RESP: if (w_fall) w_next = ST_RESP_LOW;
      ST_RESP_LOW:    if (w_rise) w_next = ST_RESP_HIGH;
      ST_RESP_HIGH:   if (w_fall) w_next = ST_BIT_LOW;
      ST_BIT_LOW:     if (w_rise) w_next = ST_BIT_HIGH;
      ST_BIT_HIGH:    if (w_fall) w_next = w_last_bit ? ST_FIM : ST_BIT_LOW;
      ST_FIM:         w_next = ST_IDLE;
      default:        w_next = ST_IDLE;
    endcase
    if (w_phase_to && (w_next == r_state)) begin
      w_next           = ST_FIM;
      w_to_fim_timeout = 1'b1;
    end
  end

  // State, phase counter, bit index, shift register and edge history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_timeout  <= 1'b0;
      r_bus_prev <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_bus_prev <= w_bus_s;
      if ((w_next != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
      else                                             r_cnt <= r_cnt + 32'd1;
      if ((r_state == ST_IDLE) && medir) begin
        r_shift   <= '0;
        r_idx     <= '0;
        r_timeout <= 1'b0;
      end
      if (w_to_fim_timeout) r_timeout <= 1'b1;
      if ((r_state == ST_RESP_HIGH) && w_fall) r_idx <= '0;
      if ((r_state == ST_BIT_HIGH) && w_fall) begin
        r_shift <= {r_shift[38:0], w_bit};
        r_idx   <= r_idx + 6'd1;
      end
    end
  end

  // Result registers: cleared status on a new request, whole update in FIM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pronto  <= 1'b0;
      r_erro    <= 1'b0;
      r_erro_cs <= 1'b0;
      r_temp    <= '0;
      r_umid    <= '0;
    end else begin
      r_pronto <= 1'b0;
      if ((r_state == ST_IDLE) && medir) begin
        r_erro    <= 1'b0;
        r_erro_cs <= 1'b0;
      end
      if (r_state == ST_FIM) begin
        r_pronto <= 1'b1;
        if (r_timeout) begin
          r_erro    <= 1'b1;
          r_erro_cs <= 1'b0;
        end else if (checksum_ok(r_shift)) begin
          r_umid    <= r_shift[39:24];
          r_temp    <= r_shift[23:8];
          r_erro    <= 1'b0;
          r_erro_cs <= 1'b0;
        end else begin
          r_erro    <= 1'b1;
          r_erro_cs <= 1'b1;
        end
      end
    end
  end

  assign pronto        = r_pronto;
  assign erro          = r_erro;
  assign erro_checksum = r_erro_cs;
  assign temperatura   = r_temp;
  assign umidade       = r_umid;
  assign db_estado     = r_state;

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a behavioural DHT11 on a pulled-up bus.
module tb_dht11_reader;

  localparam int unsigned P_START = 100;
  localparam int unsigned P_LIM   = 20;
  localparam int unsigned P_TO    = 50;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        sensor_low;
  wire         dht_bus;
  logic        pronto;
  logic        erro;
  logic        erro_checksum;
  logic [15:0] temperatura;
  logic [15:0] umidade;
  logic [2:0]  db_estado;

  int n_cmp;
  int n_fail;
  int pronto_cnt;
  int bus_bad;
  bit mon_en;
  logic [2:0] trace_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] last_state;

  pullup (dht_bus);
  assign dht_bus = sensor_low ? 1'b0 : 1'bz;

  dht11_reader #(
    .START_LOW_CICLOS (P_START),
    .LIMIAR_BIT       (P_LIM),
    .TIMEOUT_FASE     (P_TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .medir         (medir),
    .dht_bus       (dht_bus),
    .pronto        (pronto),
    .erro          (erro),
    .erro_checksum (erro_checksum),
    .temperatura   (temperatura),
    .umidade       (umidade),
    .db_estado     (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // monitors: pronto pulses, state trace, bus level sanity
  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cnt++;
    if (db_estado !== last_state) begin
      trace_q.push_back(db_estado);
      last_state = db_estado;
    end
    if (mon_en) begin
      if (db_estado == 3'd1) begin
        if (dht_bus !== 1'b0) bus_bad++;
      end else if (!sensor_low) begin
        if (dht_bus !== 1'b1) bus_bad++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // driver: host request, optionally with an extra medir while in START_LOW
  task automatic start_tx(input bit extra_medir, input string tag);
    int k;
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    if (extra_medir) begin
      wait_cyc(10);
      medir = 1'b1;
      @(negedge clock);
      medir = 1'b0;
    end
    k = 0;
    while (db_estado != 3'd2 && k < 300) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_release"}, 32'(db_estado), 32'd2);
    wait_cyc(5);
  endtask

  // driver: sensor response then n bits MSB first; medir pulsed in bit medir_bit
  task automatic send_bits(input logic [39:0] f, input int n, input int w0, input int w1,
                           input int medir_bit);
    int w;
    sensor_low = 1'b1; wait_cyc(15);
    sensor_low = 1'b0; wait_cyc(15);
    for (int i = 0; i < n; i++) begin
      w = f[39 - i] ? w1 : w0;
      sensor_low = 1'b1; wait_cyc(10);
      sensor_low = 1'b0;
      if (i == medir_bit) begin
        wait_cyc(3);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        wait_cyc(w - 4);
      end else begin
        wait_cyc(w);
      end
    end
  endtask

  task automatic end_frame();
    sensor_low = 1'b1; wait_cyc(10);
    sensor_low = 1'b0; wait_cyc(5);
  endtask

  task automatic wait_pronto(input int base, input int budget, input string tag);
    int k;
    k = 0;
    while (pronto_cnt == base && k < budget) begin
      @(negedge clock);
      k++;
    end
    wait_cyc(3);
    check({tag, "_pronto"}, 32'(pronto_cnt - base), 32'd1);
  endtask

  task automatic full_frame(input logic [39:0] f, input int w0, input int w1, input string tag);
    int base;
    base = pronto_cnt;
    start_tx(1'b0, tag);
    send_bits(f, 40, w0, w1, -1);
    end_frame();
    wait_pronto(base, 60, tag);
  endtask

  task automatic check_result(input string tag, input logic [15:0] u, input logic [15:0] t,
                              input logic e, input logic ec);
    check({tag, "_umidade"}, 32'(umidade), 32'(u));
    check({tag, "_temperatura"}, 32'(temperatura), 32'(t));
    check({tag, "_erro"}, 32'(erro), 32'(e));
    check({tag, "_erro_cs"}, 32'(erro_checksum), 32'(ec));
    check({tag, "_idle"}, 32'(db_estado), 32'd0);
  endtask

  initial begin
    int base;
    int cyc;
    n_cmp = 0; n_fail = 0; pronto_cnt = 0; bus_bad = 0; mon_en = 1'b0;
    last_state = 3'd0;
    reset = 1'b1; medir = 1'b0; sensor_low = 1'b0;
    wait_cyc(3);
    check("rst_state", 32'(db_estado), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_bus", 32'(dht_bus), 32'd1);
    check_result("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    wait_cyc(3);

    // 1: nominal frame, 55 % / 25 C
    full_frame(40'h37_00_19_00_50, 13, 35, "c1");
    check_result("c1", 16'h3700, 16'h1900, 1'b0, 1'b0);

    // 2: bad checksum, outputs hold
    full_frame(40'h37_00_19_00_51, 13, 35, "c2");
    check_result("c2", 16'h3700, 16'h1900, 1'b1, 1'b1);

    // 4: widths exactly 19 -> '0' and 20 -> '1'
    full_frame(40'h2A_05_17_03_49, 19, 20, "c4");
    check_result("c4", 16'h2A05, 16'h1703, 1'b0, 1'b0);

    // 8-bit truncating checksum: FF+FF+01+02 = 0x201 -> 0x01
    full_frame(40'hFF_FF_01_02_01, 13, 35, "trunc");
    check_result("trunc", 16'hFFFF, 16'h0102, 1'b0, 1'b0);

    // all-zero frame is valid
    full_frame(40'h00_00_00_00_00, 13, 35, "zero");
    check_result("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);

    full_frame(40'h37_00_19_00_50, 13, 35, "c1b");
    check_result("c1b", 16'h3700, 16'h1900, 1'b0, 1'b0);

    // 3: sensor silent -> timeout in ESPERA_RESP, pronto 152 edges after request edge
    trace_q.delete();
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    cyc = 1;
    while (pronto !== 1'b1 && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    check("c3_latency", 32'(cyc), 32'd153);
    wait_cyc(3);
    check_result("c3", 16'h3700, 16'h1900, 1'b1, 1'b0);
    exp_q = '{3'd1, 3'd2, 3'd7, 3'd0};
    check("c3_trace_len", 32'(trace_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < trace_q.size(); i++)
      check($sformatf("c3_trace%0d", i), 32'(trace_q[i]), 32'(exp_q[i]));

    // timeout during the 40th bit's high phase
    base = pronto_cnt;
    start_tx(1'b0, "to40");
    send_bits(40'h2A_05_17_03_49, 39, 13, 35, -1);
    sensor_low = 1'b1; wait_cyc(10);
    sensor_low = 1'b0;
    wait_pronto(base, 120, "to40");
    check_result("to40", 16'h3700, 16'h1900, 1'b1, 1'b0);

    // 6: medir in START_LOW and in BIT_HIGH ignored, single pronto
    base = pronto_cnt;
    start_tx(1'b1, "c6");
    send_bits(40'h2A_05_17_03_49, 40, 13, 35, 5);
    end_frame();
    wait_cyc(250);
    check("c6_single_pronto", 32'(pronto_cnt - base), 32'd1);
    check_result("c6", 16'h2A05, 16'h1703, 1'b0, 1'b0);

    // 5: reset during bit 17's high phase
    start_tx(1'b0, "c5");
    send_bits(40'h37_00_19_00_50, 17, 13, 35, -1);
    sensor_low = 1'b1; wait_cyc(10);
    sensor_low = 1'b0; wait_cyc(5);
    check("c5_in_bit_high", 32'(db_estado), 32'd6);
    reset = 1'b1;
    #1;
    check("c5_bus", 32'(dht_bus), 32'd1);
    check_result("c5", 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(3);

    // reset while the host is pulling the bus low releases it at once
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    wait_cyc(20);
    check("rst_sl_driven", 32'(dht_bus), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_sl_bus", 32'(dht_bus), 32'd1);
    check("rst_sl_state", 32'(db_estado), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(3);

    // request after reset completes normally
    full_frame(40'h37_00_19_00_50, 13, 35, "c5b");
    check_result("c5b", 16'h3700, 16'h1900, 1'b0, 1'b0);

    check("bus_level", 32'(bus_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #3000000;
    n_fail++;
    $display("FAIL global_timeout: observed no end expected end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
